// File: rtl/fft4_ctrl.sv
// Serial-to-parallel front end for a 4-point binary-input FFT.
// Collects four samples, runs fft4 and holds the result under valid/ready.

module fft4 (
   input  logic [3:0] inp,
   output logic [2:0] rout_0,
   output logic [2:0] rout_1,
   output logic [2:0] rout_2,
   output logic [2:0] rout_3,
   output logic [2:0] iout_0,
   output logic [2:0] iout_1,
   output logic [2:0] iout_2,
   output logic [2:0] iout_3
);

   logic [2:0] w_x0;
   logic [2:0] w_x1;
   logic [2:0] w_x2;
   logic [2:0] w_x3;

   assign w_x0 = {2'b00, inp[0]};
   assign w_x1 = {2'b00, inp[1]};
   assign w_x2 = {2'b00, inp[2]};
   assign w_x3 = {2'b00, inp[3]};

   // 3-bit two's complement; bin 0 of 4'b1111 wraps to 3'b100
   assign rout_0 = w_x0 + w_x1 + w_x2 + w_x3;
   assign iout_0 = 3'b000;
   assign rout_1 = w_x0 - w_x2;
   assign iout_1 = w_x3 - w_x1;
   assign rout_2 = w_x0 - w_x1 + w_x2 - w_x3;
   assign iout_2 = 3'b000;
   assign rout_3 = w_x0 - w_x2;
   assign iout_3 = w_x1 - w_x3;

endmodule

module fft4_ctrl #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_bit,
   output logic             s_ready,
   input  logic             sync,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [2:0]       rout_0,
   output logic [2:0]       rout_1,
   output logic [2:0]       rout_2,
   output logic [2:0]       rout_3,
   output logic [2:0]       iout_0,
   output logic [2:0]       iout_1,
   output logic [2:0]       iout_2,
   output logic [2:0]       iout_3,
   output logic [CNT_W-1:0] frame_cnt
);

   logic [3:0]       r_smp;
   logic [2:0]       r_scnt;
   logic             r_m_valid;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [2:0]       r_rout_0;
   logic [2:0]       r_rout_1;
   logic [2:0]       r_rout_2;
   logic [2:0]       r_rout_3;
   logic [2:0]       r_iout_0;
   logic [2:0]       r_iout_1;
   logic [2:0]       r_iout_2;
   logic [2:0]       r_iout_3;

   logic       w_full;
   logic       w_acc;
   logic       w_xfer;
   logic [2:0] w_rout_0;
   logic [2:0] w_rout_1;
   logic [2:0] w_rout_2;
   logic [2:0] w_rout_3;
   logic [2:0] w_iout_0;
   logic [2:0] w_iout_1;
   logic [2:0] w_iout_2;
   logic [2:0] w_iout_3;

   fft4 u_fft4 (
      .inp    (r_smp),
      .rout_0 (w_rout_0),
      .rout_1 (w_rout_1),
      .rout_2 (w_rout_2),
      .rout_3 (w_rout_3),
      .iout_0 (w_iout_0),
      .iout_1 (w_iout_1),
      .iout_2 (w_iout_2),
      .iout_3 (w_iout_3)
   );

   assign w_full  = (r_scnt == 3'd4);
   assign s_ready = !w_full;
   assign w_acc   = s_valid && !w_full;
   // acceptance and transfer are mutually exclusive: one needs scnt<4, the other scnt==4
   assign w_xfer  = w_full && (!r_m_valid || m_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_smp       <= 4'b0000;
         r_scnt      <= 3'd0;
         r_m_valid   <= 1'b0;
         r_frame_cnt <= '0;
         r_rout_0    <= 3'b000;
         r_rout_1    <= 3'b000;
         r_rout_2    <= 3'b000;
         r_rout_3    <= 3'b000;
         r_iout_0    <= 3'b000;
         r_iout_1    <= 3'b000;
         r_iout_2    <= 3'b000;
         r_iout_3    <= 3'b000;
      end else begin
         if (w_xfer) begin
            r_rout_0    <= w_rout_0;
            r_rout_1    <= w_rout_1;
            r_rout_2    <= w_rout_2;
            r_rout_3    <= w_rout_3;
            r_iout_0    <= w_iout_0;
            r_iout_1    <= w_iout_1;
            r_iout_2    <= w_iout_2;
            r_iout_3    <= w_iout_3;
            r_m_valid   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end

         if (sync) begin
            if (w_acc) begin
               r_smp[0] <= s_bit;
               r_scnt   <= 3'd1;
            end else begin
               r_scnt <= 3'd0;
            end
         end else if (w_acc) begin
            r_smp[r_scnt[1:0]] <= s_bit;
            r_scnt             <= r_scnt + 3'd1;
         end else if (w_xfer) begin
            r_scnt <= 3'd0;
         end
      end
   end

   assign m_valid   = r_m_valid;
   assign frame_cnt = r_frame_cnt;
   assign rout_0    = r_rout_0;
   assign rout_1    = r_rout_1;
   assign rout_2    = r_rout_2;
   assign rout_3    = r_rout_3;
   assign iout_0    = r_iout_0;
   assign iout_1    = r_iout_1;
   assign iout_2    = r_iout_2;
   assign iout_3    = r_iout_3;

endmodule

// File: tb/tb_fft4_ctrl.sv
// Directed bench for fft4_ctrl with hand-computed fft4 results.
// Runs the DUT with CNT_W=2 so the frame counter wrap is reachable.

module tb_fft4_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic       s_bit;
   logic       s_ready;
   logic       sync;
   logic       m_valid;
   logic       m_ready;
   logic [2:0] rout_0, rout_1, rout_2, rout_3;
   logic [2:0] iout_0, iout_1, iout_2, iout_3;
   logic [1:0] frame_cnt;

   int n_chk = 0;
   int n_err = 0;

   // packed as {rout_0..rout_3, iout_0..iout_3}
   localparam logic [23:0] E1011 = {3'b011, 3'b001, 3'b111, 3'b001, 12'b0};
   localparam logic [23:0] E1000 = {3'b001, 3'b000, 3'b111, 3'b000,
                                    3'b000, 3'b001, 3'b000, 3'b111};
   localparam logic [23:0] E0101 = {3'b010, 3'b000, 3'b010, 3'b000, 12'b0};
   localparam logic [23:0] E1110 = {3'b011, 3'b111, 3'b111, 3'b111, 12'b0};
   localparam logic [23:0] E1111 = {3'b100, 9'b0, 12'b0};
   localparam logic [23:0] E0001 = {3'b001, 3'b001, 3'b001, 3'b001, 12'b0};
   localparam logic [23:0] E0000 = 24'b0;

   logic [23:0] w_out;
   assign w_out = {rout_0, rout_1, rout_2, rout_3,
                   iout_0, iout_1, iout_2, iout_3};

   fft4_ctrl #(.CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_bit     (s_bit),
      .s_ready   (s_ready),
      .sync      (sync),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .rout_0    (rout_0),
      .rout_1    (rout_1),
      .rout_2    (rout_2),
      .rout_3    (rout_3),
      .iout_0    (iout_0),
      .iout_1    (iout_1),
      .iout_2    (iout_2),
      .iout_3    (iout_3),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [3:0] inp);
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1;
         s_bit   = inp[k];
         step();
      end
      s_valid = 1'b0;
   endtask

   logic [3:0]  fr [5];
   logic [23:0] ex [5];

   initial begin
      fr = '{4'b0001, 4'b0000, 4'b1111, 4'b1011, 4'b1110};
      ex = '{E0001, E0000, E1111, E1011, E1110};

      rst     = 1'b1;
      sync    = 1'b0;
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_bit   = 1'b1;
      step();
      chk("rst_s_ready", s_ready, 1);
      step();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_out", w_out, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_s_ready2", s_ready, 1);
      rst     = 1'b0;
      s_valid = 1'b0;
      step();
      chk("idle_s_ready", s_ready, 1);

      // first frame, inp = 4'b1011
      feed(4'b1011);
      chk("f1_s_ready_lo", s_ready, 0);
      chk("f1_latency", m_valid, 0);
      step();
      chk("f1_m_valid", m_valid, 1);
      chk("f1_out", w_out, E1011);
      chk("f1_cnt", frame_cnt, 1);
      chk("f1_s_ready_hi", s_ready, 1);

      // backpressure: second frame waits behind the held first result
      m_ready = 1'b0;
      feed(4'b1000);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_out", w_out, E1011);
      s_valid = 1'b1;
      s_bit   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_hold_out", w_out, E1011);
         chk("bp_hold_v", m_valid, 1);
         chk("bp_hold_rdy", s_ready, 0);
         chk("bp_hold_cnt", frame_cnt, 1);
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("f2_m_valid", m_valid, 1);
      chk("f2_out", w_out, E1000);
      chk("f2_cnt", frame_cnt, 2);
      chk("f2_s_ready", s_ready, 1);

      m_ready = 1'b1;
      feed(4'b0101);
      chk("f3_pre_v", m_valid, 0);
      step();
      chk("f3_out", w_out, E0101);
      chk("f3_cnt", frame_cnt, 3);
      chk("f3_m_valid", m_valid, 1);

      // sync restarts the frame with the coincident sample as sample 0
      s_valid = 1'b1;
      s_bit   = 1'b1;
      step();
      step();
      sync  = 1'b1;
      s_bit = 1'b0;
      step();
      sync = 1'b0;
      chk("sync_s_ready", s_ready, 1);
      s_bit = 1'b1;
      step();
      step();
      step();
      s_valid = 1'b0;
      chk("sync_full", s_ready, 0);
      step();
      chk("sync_out", w_out, E1110);
      chk("sync_cnt_wrap", frame_cnt, 0);
      chk("sync_m_valid", m_valid, 1);

      feed(4'b1111);
      step();
      chk("f5_out", w_out, E1111);
      chk("f5_cnt", frame_cnt, 1);

      // reset mid-frame with a held result
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_bit   = 1'b1;
      step();
      s_bit = 1'b0;
      step();
      s_bit = 1'b1;
      step();
      chk("pre_rst_v", m_valid, 1);
      chk("pre_rst_rdy", s_ready, 1);
      rst     = 1'b1;
      sync    = 1'b1;
      m_ready = 1'b1;
      step();
      chk("mid_rst_v", m_valid, 0);
      chk("mid_rst_out", w_out, 0);
      chk("mid_rst_cnt", frame_cnt, 0);
      chk("mid_rst_rdy", s_ready, 1);
      rst  = 1'b0;
      sync = 1'b0;

      // full-rate streaming: one frame every 5 cycles
      s_valid = 1'b1;
      for (int t = 1; t <= 25; t++) begin
         int f;
         int ph;
         f  = (t - 1) / 5;
         ph = (t - 1) % 5;
         s_bit = (ph < 4) ? fr[f][ph] : 1'b0;
         step();
         if (ph == 3) begin
            chk("fr_s_ready_lo", s_ready, 0);
            chk("fr_not_yet", m_valid, 0);
         end else if (ph == 4) begin
            chk("fr_m_valid", m_valid, 1);
            chk("fr_out", w_out, ex[f]);
            chk("fr_cnt", frame_cnt, (f + 1) % 4);
            chk("fr_s_ready_hi", s_ready, 1);
         end else if (ph == 0 && t > 1) begin
            chk("fr_v_clear", m_valid, 0);
         end
      end
      s_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fft4_ctrl.md
FFT4_CTRL -- requirements
Module: fft4_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the frame counter.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port s_valid, input, 1, serial sample present on s_bit.
REQ-006 The block SHALL have port s_bit, input, 1, one real binary sample.
REQ-007 The block SHALL have port s_ready, output, 1, the block can accept a sample this cycle.
REQ-008 The block SHALL have port sync, input, 1, frame restart that discards the partially collected frame.
REQ-009 The block SHALL have port m_valid, output, 1, the registered FFT result is valid.
REQ-010 The block SHALL have port m_ready, input, 1, the consumer takes the result this cycle.
REQ-011 The block SHALL have ports rout_0..rout_3 and iout_0..iout_3, output, 3 each, the registered fft4 outputs with names matching the fft4 ports.
REQ-012 The block SHALL have port frame_cnt, output, CNT_W, the number of frames delivered to the output register, modulo 2^CNT_W.

Function
REQ-013 The block SHALL instantiate exactly one combinational fft4 with ports inp[3:0], rout_0..3[2:0] and iout_0..3[2:0], and SHALL drive inp from an internal sample register smp[3:0].
REQ-014 The block SHALL keep a sample count scnt in the range 0..4, and s_ready SHALL equal (scnt != 4), combinationally.
REQ-015 A sample is accepted when s_valid and s_ready are both high at a clock edge: smp[scnt] <= s_bit and scnt <= scnt+1, so the first accepted sample goes to inp[0] and the fourth to inp[3].
REQ-016 Transfer condition: (scnt == 4) and (!m_valid or m_ready).
- On transfer, the output registers SHALL load the fft4 outputs, m_valid <= 1, scnt <= 0, and frame_cnt <= frame_cnt+1.
REQ-017 When m_valid and m_ready are both high with no transfer, m_valid SHALL clear to 0.
- When they are both high with a transfer, m_valid SHALL stay 1 and new data SHALL replace the old in the same edge.
REQ-018 Output data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-019 Latency: if the 4th sample is accepted at edge E and the output register is free, m_valid SHALL be high after edge E+1.
- Peak throughput SHALL be one frame per 5 cycles, with s_ready low for exactly one cycle per frame when there is no backpressure.
REQ-020 Backpressure: while scnt=4 and m_valid=1 and m_ready=0, s_ready SHALL stay 0, smp SHALL hold, and no sample SHALL be lost.
REQ-021 sync=1 SHALL set scnt to 0 and leave the output registers, m_valid and frame_cnt unchanged.
- If sync=1 coincides with an accepted sample, that sample SHALL become sample 0 (smp[0] <= s_bit, scnt <= 1).
- If sync=1 coincides with a transfer, the transfer SHALL complete and scnt SHALL become 0.
REQ-022 frame_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-023 smp bits not yet written in the current frame SHALL retain their old values; they are unobservable because transfer requires scnt=4.

Reset
REQ-024 On an edge with rst=1, the block SHALL set: scnt=0, smp=4'b0000, m_valid=0, all rout_*/iout_* = 3'b000, frame_cnt=0.
- rst SHALL take priority over sync, sample acceptance and transfer.
REQ-025 While rst=1, s_ready SHALL read 1 (scnt=0), and samples presented during reset SHALL be discarded.
REQ-026 rst asserted mid-frame or with m_valid=1 SHALL discard both the partial frame and the held result.

Verification
REQ-027 Reset, then feed bits 1,1,0,1 with s_valid=1 continuously and m_ready=1 -> inp=4'b1011; m_valid high one cycle after the 4th acceptance; outputs equal fft4(4'b1011); frame_cnt=1.
REQ-028 Hold m_ready=0 after the first frame and stream 8 more bits -> the second frame completes, s_ready=0 with scnt=4, and the first result stays stable.
- Then raise m_ready for one cycle -> the second result loads in that same edge, m_valid stays 1, and frame_cnt=2.
REQ-029 Feed 2 bits, pulse sync together with s_bit=0 accepted, then feed 1,1,1 -> inp=4'b1110; the earlier 2 bits are discarded.
REQ-030 Assert rst with scnt=3 and m_valid=1 -> after the edge, m_valid=0, outputs=0, frame_cnt=0, and s_ready=1.
REQ-031 With CNT_W=2, run 5 frames with m_ready=1 -> frame_cnt sequence 1,2,3,0,1, and each frame takes 5 cycles at full rate.
